// File: rtl/customer_source_pkg.sv
// Shared definitions for the customer arrival generator: state encoding,
// LFSR geometry and customer-number limits.
package customer_source_pkg;

  localparam logic [2:0] ST_IDLE_E = 3'd0;
  localparam logic [2:0] ST_GAP_E  = 3'd1;
  localparam logic [2:0] ST_HOLD_E = 3'd2;
  localparam logic [2:0] ST_SEND_E = 3'd3;
  localparam logic [2:0] ST_DONE_E = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_E,
    ST_GAP  = ST_GAP_E,
    ST_HOLD = ST_HOLD_E,
    ST_SEND = ST_SEND_E,
    ST_DONE = ST_DONE_E
  } src_state_t;

  localparam int LFSR_W = 8;
  localparam int TAP0   = 7;
  localparam int TAP1   = 5;
  localparam int TAP2   = 4;
  localparam int TAP3   = 3;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

  // Customer numbers run 1..NUM_WRAP; NUM_EMPTY marks "no customer".
  localparam int NUM_WRAP  = 15;
  localparam int NUM_EMPTY = 0;

endpackage

// File: rtl/src_lfsr.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3) that advances only when step is high.
module src_lfsr
  import customer_source_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic fb;

  assign fb = q[TAP0] ^ q[TAP1] ^ q[TAP2] ^ q[TAP3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/customer_source.sv
// Customer arrival generator feeding the queue write side; honours full.
// Optional SRC_RANDOM_GAP_EN draws inter-arrival gaps from the LFSR.
module customer_source
  import customer_source_pkg::*;
#(
  parameter int                DT_SZ = 4,
  parameter int                GAP_W = 4,
  parameter int                CNT_W = 8,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             full,
  input  logic [GAP_W-1:0] gap_max,
  input  logic [CNT_W-1:0] cust_max,
  output logic             out_valid,
  output logic [DT_SZ-1:0] out_num,
  output logic [DT_SZ-1:0] out_time,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             done
);

  src_state_t        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_val;
  logic [DT_SZ-1:0]  num_reg;
  logic [DT_SZ-1:0]  num_nxt;
  logic [DT_SZ-1:0]  time_val;
  logic [CNT_W-1:0]  sent_nxt;
  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr;

  // A zero service time is meaningless to the counter, so clamp it to 1.
  function automatic logic [DT_SZ-1:0] sat_time(input logic [DT_SZ-1:0] raw);
    return (raw == '0) ? DT_SZ'(1) : raw;
  endfunction

  function automatic logic [DT_SZ-1:0] wrap_num(input logic [DT_SZ-1:0] cur);
    return (cur == DT_SZ'(NUM_WRAP)) ? DT_SZ'(1) : cur + 1'b1;
  endfunction

  src_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (en),
    .q     (lfsr_q)
  );

`ifdef SRC_RANDOM_GAP_EN
  assign gap_val = lfsr_q[GAP_W+3:4] & gap_max;
`else
  assign gap_val = gap_max;
`endif

  assign unused_lfsr = ^lfsr_q;
  assign time_val    = sat_time(lfsr_q[DT_SZ-1:0]);
  assign num_nxt     = wrap_num(num_reg);
  assign sent_nxt    = sent_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      num_reg   <= DT_SZ'(1);
      sent_cnt  <= '0;
      out_valid <= 1'b0;
      out_num   <= DT_SZ'(NUM_EMPTY);
      out_time  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_num   <= DT_SZ'(NUM_EMPTY);
      out_time  <= '0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          sent_cnt <= '0;
          if (en) begin
            state   <= ST_GAP;
            gap_cnt <= gap_val;
          end
        end
        ST_GAP: begin
          if (!en) begin
            state    <= ST_IDLE;
            sent_cnt <= '0;
          end else if (gap_cnt == '0) begin
            state <= ST_HOLD;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          // en=0 takes priority over a simultaneous full release.
          if (!en) begin
            state    <= ST_IDLE;
            sent_cnt <= '0;
          end else if (!full) begin
            state     <= ST_SEND;
            out_valid <= 1'b1;
            out_num   <= num_reg;
            out_time  <= time_val;
          end
        end
        ST_SEND: begin
          // Completes regardless of en; full cannot rise before next HOLD.
          num_reg  <= num_nxt;
          sent_cnt <= sent_nxt;
          if ((cust_max != '0) && (sent_nxt == cust_max)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state   <= ST_GAP;
            gap_cnt <= gap_val;
          end
        end
        ST_DONE: begin
          if (!en) begin
            state    <= ST_IDLE;
            sent_cnt <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_customer_source.sv
// Scoreboard bench for customer_source: expected strobes are queued at
// stimulus time and matched against the DUT together with an LFSR model.
module tb_customer_source;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       full;
  logic [3:0] gap_max;
  logic [7:0] cust_max;
  logic       out_valid;
  logic [3:0] out_num;
  logic [3:0] out_time;
  logic [7:0] sent_cnt;
  logic       done;

  typedef struct {
    logic [3:0] n;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  customer_source dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .full      (full),
    .gap_max   (gap_max),
    .cust_max  (cust_max),
    .out_valid (out_valid),
    .out_num   (out_num),
    .out_time  (out_time),
    .sent_cnt  (sent_cnt),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: m_prev is the value the DUT saw before the latest edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      if (en) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  function automatic logic [3:0] exp_time(input logic [7:0] q);
    return (q[3:0] == 4'd0) ? 4'd1 : q[3:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    full  = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    int   t0;
    bit   hit;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0d want 0", out_valid); end
    total++; if (out_num !== 4'd0)   begin bad++; $display("FAIL rst_num: got %0d want 0", out_num); end
    total++; if (out_time !== 4'd0)  begin bad++; $display("FAIL rst_time: got %0d want 0", out_time); end
    total++; if (sent_cnt !== 8'd0)  begin bad++; $display("FAIL rst_sent: got %0d want 0", sent_cnt); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %0d want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    gap_max = 4'd0; cust_max = 8'd0;
    @(negedge clk);
    en = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      hit = out_valid;
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_reach_send: got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %0d want 0", out_valid); end
    total++; if (out_num !== 4'd0)   begin bad++; $display("FAIL arst_num: got %0d want 0", out_num); end
    total++; if (out_time !== 4'd0)  begin bad++; $display("FAIL arst_time: got %0d want 0", out_time); end
    total++; if (sent_cnt !== 8'd0)  begin bad++; $display("FAIL arst_sent: got %0d want 0", sent_cnt); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL arst_done: got %0d want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{n: 4'd1, t: t0 + 2});
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        total++; if (out_num !== e.n) begin bad++; $display("FAIL rst_first_num: got %0d want %0d", out_num, e.n); end
        total++; if (cyc != e.t) begin bad++; $display("FAIL rst_first_cyc: got %0d want %0d", cyc, e.t); end
        total++; if (out_time !== exp_time(m_prev)) begin bad++; $display("FAIL rst_first_time: got %0d want %0d", out_time, exp_time(m_prev)); end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rst_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_fixed_gap();
    exp_t e;
    int   t0;
    do_reset();
    gap_max = 4'd2; cust_max = 8'd3;
    en = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 3; i++) sb.push_back('{n: 4'(i + 1), t: t0 + 4 + 5 * i});
    for (int k = 0; k < 30 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        total++; if (out_num !== e.n) begin bad++; $display("FAIL fix_num: got %0d want %0d", out_num, e.n); end
        total++; if (cyc != e.t) begin bad++; $display("FAIL fix_cyc: got %0d want %0d", cyc, e.t); end
        total++; if (out_time !== exp_time(m_prev)) begin bad++; $display("FAIL fix_time: got %0d want %0d", out_time, exp_time(m_prev)); end
      end else begin
        total++; if (out_num !== 4'd0 || out_time !== 4'd0) begin bad++; $display("FAIL fix_idle_data: got %0d/%0d want 0/0", out_num, out_time); end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL fix_pending: got %0d want 0", sb.size()); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL fix_done: got %0d want 1", done); end
    total++; if (sent_cnt !== 8'd3) begin bad++; $display("FAIL fix_sent: got %0d want 3", sent_cnt); end
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL fix_done_hold: got %0d/%0d want 1/0", done, out_valid); end
    en = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL fix_done_clear: got %0d want 0", done); end
    total++; if (sent_cnt !== 8'd0) begin bad++; $display("FAIL fix_sent_clear: got %0d want 0", sent_cnt); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   t0;
    bit   seen;
    do_reset();
    gap_max = 4'd1; cust_max = 8'd0;
    full = 1'b1;
    en = 1'b1;
    t0 = cyc + 1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL bp_blocked: got 1 want 0"); end
    total++; if (cyc != t0 + 11) begin bad++; $display("FAIL bp_sync: got %0d want %0d", cyc, t0 + 11); end
    full = 1'b0;
    sb.push_back('{n: 4'd1, t: cyc + 1});
    sb.push_back('{n: 4'd2, t: cyc + 5});
    for (int k = 0; k < 12 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        total++; if (out_num !== e.n) begin bad++; $display("FAIL bp_num: got %0d want %0d", out_num, e.n); end
        total++; if (cyc != e.t) begin bad++; $display("FAIL bp_cyc: got %0d want %0d", cyc, e.t); end
        total++; if (out_time !== exp_time(m_prev)) begin bad++; $display("FAIL bp_time: got %0d want %0d", out_time, exp_time(m_prev)); end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   t0;
    do_reset();
    gap_max = 4'd0; cust_max = 8'd0;
    en = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 16; i++) sb.push_back('{n: 4'((i % 15) + 1), t: t0 + 2 + 3 * i});
    for (int k = 0; k < 70 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        total++; if (out_num !== e.n) begin bad++; $display("FAIL wrap_num: got %0d want %0d", out_num, e.n); end
        total++; if (cyc != e.t) begin bad++; $display("FAIL wrap_cyc: got %0d want %0d", cyc, e.t); end
        total++; if (out_time !== exp_time(m_prev)) begin bad++; $display("FAIL wrap_time: got %0d want %0d", out_time, exp_time(m_prev)); end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL wrap_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_abort();
    exp_t e;
    int   t0;
    bit   seen;
    do_reset();
    gap_max = 4'd5; cust_max = 8'd0;
    en = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{n: 4'd1, t: t0 + 7});
    for (int k = 0; k < 15 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        total++; if (out_num !== e.n) begin bad++; $display("FAIL ab_num: got %0d want %0d", out_num, e.n); end
        total++; if (cyc != e.t) begin bad++; $display("FAIL ab_cyc: got %0d want %0d", cyc, e.t); end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL ab_pending: got %0d want 0", sb.size()); end
    @(negedge clk);
    total++; if (sent_cnt !== 8'd1) begin bad++; $display("FAIL ab_sent_pre: got %0d want 1", sent_cnt); end
    en = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL ab_no_strobe: got 1 want 0"); end
    total++; if (sent_cnt !== 8'd0) begin bad++; $display("FAIL ab_sent_clear: got %0d want 0", sent_cnt); end
    en = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{n: 4'd2, t: t0 + 7});
    for (int k = 0; k < 15 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        total++; if (out_num !== e.n) begin bad++; $display("FAIL ab_resume_num: got %0d want %0d", out_num, e.n); end
        total++; if (cyc != e.t) begin bad++; $display("FAIL ab_resume_cyc: got %0d want %0d", cyc, e.t); end
        total++; if (out_time !== exp_time(m_prev)) begin bad++; $display("FAIL ab_resume_time: got %0d want %0d", out_time, exp_time(m_prev)); end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL ab_resume_pending: got %0d want 0", sb.size()); end
    @(negedge clk);
    total++; if (sent_cnt !== 8'd1) begin bad++; $display("FAIL ab_sent_restart: got %0d want 1", sent_cnt); end
  endtask

`ifdef SRC_RANDOM_GAP_EN
  task automatic test_random();
    exp_t e;
    int   t0;
    int   last;
    int   sends;
    logic [3:0] g;
    do_reset();
    gap_max = 4'd3; cust_max = 8'd0;
    en = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    g = m_prev[7:4] & gap_max;
    sb.push_back('{n: 4'd1, t: t0 + int'(g) + 2});
    last  = t0 - 1;
    sends = 0;
    for (int k = 0; k < 2000 && sends < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected: got strobe at %0d want none", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.t || out_num !== e.n) begin
            bad++; $display("FAIL rnd_strobe: got cyc %0d num %0d want cyc %0d num %0d", cyc, out_num, e.t, e.n);
          end
        end
        total++; if (out_time == 4'd0 || out_time !== exp_time(m_prev)) begin bad++; $display("FAIL rnd_time: got %0d want %0d", out_time, exp_time(m_prev)); end
        if (sends > 0) begin
          total++; if (cyc - last - 3 > 3 || cyc - last - 3 < 0) begin bad++; $display("FAIL rnd_gap: got %0d want 0..3", cyc - last - 3); end
        end
        last = cyc;
        sends++;
        @(negedge clk);
        g = m_prev[7:4] & gap_max;
        sb.push_back('{n: 4'((sends % 15) + 1), t: cyc + int'(g) + 2});
      end
    end
    total++; if (sends != 200) begin bad++; $display("FAIL rnd_count: got %0d want 200", sends); end
  endtask
`endif

  initial begin
    rst_n    = 1'b1;
    en       = 1'b0;
    full     = 1'b0;
    gap_max  = 4'd0;
    cust_max = 8'd0;
    test_reset();
    test_fixed_gap();
    test_backpressure();
    test_wrap();
    test_abort();
`ifdef SRC_RANDOM_GAP_EN
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/customer_source.md
# customer_source

Customer arrival generator that drives the queue's write side of the queue/dispatcher/counter system. It emits one-cycle `out_valid` pulses carrying a customer number and a service time, and it honours the queue's `full` flag so no customer is dropped. Service times come from an internal LFSR, and inter-arrival gaps are programmable. It is the producer end of the `in_valid`/`in_num`/`in_time` interface.

## Interface
- `DT_SZ`, 4: customer number and service time width.
- `GAP_W`, 4: gap field width. DT_SZ+GAP_W ≤ 8.
- `CNT_W`, 8: sent-counter and limit width.
- `SEED`, 8'hA5: LFSR reset value. Must be nonzero.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable. 0 aborts to IDLE.
- `full`  in  1  queue full flag.
- `gap_max`  in  GAP_W  gap value (fixed mode) or gap mask (random mode).
- `cust_max`  in  CNT_W  customers to send. 0 = unlimited.
- `out_valid`  out  1  one-cycle customer strobe, connects to queue `in_valid`.
- `out_num`  out  DT_SZ  customer number, 0 when `out_valid`=0.
- `out_time`  out  DT_SZ  service time 1..15, 0 when `out_valid`=0.
- `sent_cnt`  out  CNT_W  customers sent since last IDLE.
- `done`  out  1  high in DONE state.

## Operation
- LFSR, 8 bits, Fibonacci.
  - fb = q[7]^q[5]^q[4]^q[3]; next = {q[6:0], fb}.
  - Steps every cycle with `en`=1 and holds otherwise.
  - From 8'hA5: 8'h4A, then 8'h95.
- States: IDLE, GAP, HOLD, SEND, DONE. All outputs are registered or decoded from state only (Moore).
- IDLE:
  - `en`=1 → GAP; `gap_cnt` loaded with the gap value.
  - `sent_cnt` is cleared on entry.
- GAP:
  - `en`=0 → IDLE.
  - `gap_cnt`==0 → HOLD; otherwise decrement.
- HOLD:
  - `en`=0 → IDLE.
  - `full`=0 → SEND, latching `time_reg` = LFSR[DT_SZ-1:0], with 0 replaced by 1.
  - `full`=1 → stay.
- SEND:
  - `out_valid`=1, `out_num`=`num_reg`, `out_time`=`time_reg`.
  - On exit: `num_reg` increments and wraps 15→1 (0 is never emitted); `sent_cnt` increments.
  - Then DONE if `cust_max`≠0 and the new `sent_cnt`==`cust_max`; else GAP with a fresh gap value.
  - SEND always completes, even if `en` falls during it.
- DONE: `done`=1; `en`=0 → IDLE.
- `num_reg` survives IDLE (no renumbering on abort); only reset sets it to 1.
- `full` is not re-checked in SEND. This is safe because only this block writes the queue and full updates before the next HOLD.
- `en` and `full` changing in the same cycle: `en`=0 wins.

## Timing
- Reset (async) values:
  - outputs: `out_valid`=0, `out_num`=0, `out_time`=0, `sent_cnt`=0, `done`=0.
  - internal: state IDLE, `num_reg`=1, LFSR=SEED, `gap_cnt`=0.
- First strobe appears g+2 cycles after the edge sampling `en`=1 (g = gap value, `full`=0).
- Steady-state period is g+3 cycles per customer with `full`=0. Each cycle of `full`=1 seen in HOLD adds one cycle.
- `out_valid` rises the cycle after HOLD first samples `full`=0.
- `done` rises the cycle after the final SEND.

## Configuration
- `SRC_RANDOM_GAP_EN` defined: gap value = LFSR[GAP_W+3:4] & `gap_max`. Use 2^k−1 values of `gap_max` for a uniform spread.
- Not defined: gap value = `gap_max`, deterministic.

## Structure
- Shared package holds:
  - state encoding localparams;
  - LFSR width (8) and tap positions;
  - default SEED;
  - customer number wrap limit (15) and the reserved empty value 0.
- Sub-module `src_lfsr`: 8-bit LFSR with SEED parameter, `clk`, `rst_n`, `step` input, and `q` output.
- The FSM, gap counter and number/sent counters stay in `customer_source`.

## Test plan
- Reset: assert `rst_n`=0 during SEND → `out_valid`, `out_num`, `out_time`, `sent_cnt` and `done` go to 0 immediately; after release, the first customer is number 1.
- Fixed gap (macro off): `gap_max`=2, `cust_max`=3, `full`=0, `en`=1 → strobes 4, 9 and 14 cycles after the `en` sample, with `out_num` 1, 2, 3; `done`=1 the next cycle; `sent_cnt`=3.
- Backpressure: `full`=1 for 10 cycles while in HOLD → no strobe. Drop `full` → a single strobe the following cycle, with the same number and no skip.
- Wrap: `gap_max`=0, `cust_max`=0, 16 sends → `out_num` 1..15 then 1; 0 never emitted; period 3 cycles.
- Abort: `en`=0 during GAP → IDLE with no strobe. Re-enable → the next number continues and `sent_cnt` restarts at 0.
- Random (macro on): `gap_max`=3, 200 sends → `out_time` in 1..15 and every gap ≤3, all matching a bit-accurate LFSR model from SEED 8'hA5.
